// File: rtl/dw_pkg.sv
// Shared constants and state encoding for the depthwise 3x3 line-buffer path.
package dw_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int CHANNEL_NUM = 18;
  localparam int MAX_WIDTH   = 64;
  localparam int DIM_WIDTH   = 7;
  localparam int PIX_WIDTH   = CHANNEL_NUM * DATA_WIDTH;
  localparam int COL_WIDTH   = 3 * PIX_WIDTH;
  localparam int ADDR_WIDTH  = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } dw_state_e;
endpackage

// File: rtl/dw_line_ram.sv
// One row of line storage: combinational read, synchronous write, so a read
// in the same cycle as a write to that address returns the old contents.
module dw_line_ram #(
  parameter int DEPTH      = 64,
  parameter int WIDTH      = 144,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/dw_line_buffer.sv
// Raster pixel stream in, one vertical 3-pixel column per channel out, using
// two row stores (L0 = row y-2, L1 = row y-1) shifted on every accepted pixel.
module dw_line_buffer
  import dw_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIM_WIDTH-1:0] cfg_width,
  input  logic [DIM_WIDTH-1:0] cfg_height,
  input  logic [PIX_WIDTH-1:0] pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [COL_WIDTH-1:0] col_out,
  output logic                 col_valid,
  input  logic                 col_ready,
  output logic                 busy,
  output logic                 done,
  output dw_state_e            state_dbg
);
  // Handshakes: a beat moves when valid & ready are both high at a rising
  // edge; valid never waits on ready, and col_out holds while col_valid & !col_ready.
  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0] DIM_MIN = DIM_WIDTH'(3);
  localparam logic [DIM_WIDTH-1:0] DIM_MAX = DIM_WIDTH'(MAX_WIDTH);

  dw_state_e            state;
  logic [DIM_WIDTH-1:0] x, y, w_last, h_last;
  logic [PIX_WIDTH-1:0] l0_rd, l1_rd;
  logic [COL_WIDTH-1:0] col_next;
  logic                 accepting, accept, x_wrap, cfg_ok;

  assign cfg_ok    = (cfg_width >= DIM_MIN) && (cfg_width <= DIM_MAX) && (cfg_height >= DIM_MIN);
  assign accepting = (state == FILL) || (state == STREAM);
  assign pix_ready = accepting && (!col_valid || col_ready);
  assign accept    = pix_valid && pix_ready;
  assign x_wrap    = (x == w_last);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  dw_line_ram #(.DEPTH(MAX_WIDTH), .WIDTH(PIX_WIDTH)) u_l0 (
    .clk   (clk),
    .we    (accept),
    .addr  (x[ADDR_WIDTH-1:0]),
    .wdata (l1_rd),
    .rdata (l0_rd)
  );

  dw_line_ram #(.DEPTH(MAX_WIDTH), .WIDTH(PIX_WIDTH)) u_l1 (
    .clk   (clk),
    .we    (accept),
    .addr  (x[ADDR_WIDTH-1:0]),
    .wdata (pix_in),
    .rdata (l1_rd)
  );

  always_comb begin
    col_next = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      col_next[(c*3+0)*DATA_WIDTH +: DATA_WIDTH] = l0_rd[c*DATA_WIDTH +: DATA_WIDTH];
      col_next[(c*3+1)*DATA_WIDTH +: DATA_WIDTH] = l1_rd[c*DATA_WIDTH +: DATA_WIDTH];
      col_next[(c*3+2)*DATA_WIDTH +: DATA_WIDTH] = pix_in[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      w_last    <= '0;
      h_last    <= '0;
      col_out   <= '0;
      col_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (col_valid && col_ready) col_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_last <= cfg_width - DIM_ONE;
            h_last <= cfg_height - DIM_ONE;
            x      <= '0;
            y      <= '0;
            // An unusable geometry completes immediately without touching data.
            if (cfg_ok) state <= FILL;
            else        done  <= 1'b1;
          end
        end
        FILL, STREAM: begin
          if (accept) begin
            if (state == STREAM) begin
              col_out   <= col_next;
              col_valid <= 1'b1;
            end
            if (x_wrap) begin
              x <= '0;
              if (state == STREAM && y == h_last) begin
                state <= FLUSH;
              end else begin
                y <= y + DIM_ONE;
                if (state == FILL && y == DIM_ONE) state <= STREAM;
              end
            end else begin
              x <= x + DIM_ONE;
            end
          end
        end
        FLUSH: begin
          if (!col_valid || col_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dw_line_buffer.md
Name: dw_line_buffer

Overview:
- Producer side of the depthwise 3x3 window path: accepts raster-order feature-map pixels, all channels in parallel, one pixel position per beat.
- Keeps the previous two rows in on-chip line storage.
- Emits, per accepted pixel, one vertical 3-pixel column per channel. This is exactly the column stream the downstream DW window generator shifts into its 3x3 windows.
- Sits between the feature-map memory read path and the window generator.

Parameters:
CHANNEL_NUM, 18, channels processed in parallel
DATA_WIDTH, 8, bits per pixel
MAX_WIDTH, 64, maximum row width (line storage depth)
DIM_WIDTH, 7, width of cfg_width/cfg_height and internal counters (must hold MAX_WIDTH)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; latches cfg_* and begins a frame
cfg_width  input  DIM_WIDTH  row width W, 3..MAX_WIDTH
cfg_height  input  DIM_WIDTH  row count H, >=3
pix_in  input  CHANNEL_NUM*DATA_WIDTH  channel c at [c*DATA_WIDTH +: DATA_WIDTH]
pix_valid  input  1  pix_in valid
pix_ready  output  1  block accepts pix_in this cycle
col_out  output  CHANNEL_NUM*3*DATA_WIDTH  channel c row r at [(c*3+r)*DATA_WIDTH +: DATA_WIDTH]; r=0 oldest row (y-2), r=2 current row (y)
col_valid  output  1  col_out valid
col_ready  input  1  downstream accepts col_out
busy  output  1  frame in progress
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; col_out=0, col_valid=0, pix_ready=0, busy=0, done=0; counters cleared. Line storage contents are not cleared (don't-care).
- Reset mid-frame aborts immediately: no done pulse; any pending column is dropped.
- States: IDLE -> FILL -> STREAM -> FLUSH -> IDLE.
  - IDLE: pix_ready=0. On start, latch W/H, clear x,y and go to FILL.
  - If latched W<3, W>MAX_WIDTH or H<3: skip the frame. Go to IDLE with done=1 the next cycle; no pixels accepted, no output.
  - start outside IDLE is ignored.
- Accept = pix_valid & pix_ready. pix_ready = busy_accepting & (!col_valid | col_ready): a single output register with no skid buffer.
- On each accept at column x, row y:
  - Read L0[x] (row y-2) and L1[x] (row y-1).
  - Write L0[x]<=L1[x] and L1[x]<=pix_in.
  - Advance x. On wrap (x==W-1): x<=0, y<=y+1.
- FILL (y<2): accepts update storage only; no column is emitted. FILL -> STREAM after the last pixel of row 1.
- STREAM (y>=2): each accept loads col_out={pix_in, L1[x], L0[x]} per channel and sets col_valid=1 on the next cycle. Latency is 1 clock from accept to col_valid.
  - col_valid holds, with col_out stable, until col_ready is high.
  - A simultaneous col_ready and new accept reloads the register the same edge, so throughput is 1 column/clk.
- The accept of pixel (W-1,H-1) moves to FLUSH with pix_ready=0. FLUSH waits for the final col_ready handshake, then pulses done for 1 cycle and returns to IDLE.
- Exactly W*(H-2) columns per frame, in raster order of the centre-bottom pixel.
- Read-before-write at the same address is required: values read are those stored before the current write.
- Counter arithmetic is unsigned DIM_WIDTH; y never exceeds H-1.
- Back-to-back frames: start is allowed in the same cycle done is high; it is taken because the state is IDLE on the following edge.

Decomposition:
- Shared package (dw_pkg): DATA_WIDTH, CHANNEL_NUM, MAX_WIDTH, DIM_WIDTH constants; state encoding localparams IDLE/FILL/STREAM/FLUSH; a pixel-vector width constant CHANNEL_NUM*DATA_WIDTH.
- Sub-module dw_line_ram: depth MAX_WIDTH, width CHANNEL_NUM*DATA_WIDTH, combinational read, synchronous write, read-before-write. Instantiated twice (L0, L1).
- FSM, counters and output register live in dw_line_buffer.

Test Plan:
1. W=4, H=4, CHANNEL_NUM lanes all = y*16+x, col_ready=1, pix_valid=1.
   - Required: 8 columns, first col_out lane r0/r1/r2 = 0x00/0x10/0x20, last = 0x13/0x23/0x33.
   - done one cycle after the last col_valid handshake.
2. Same frame with col_ready toggling 1,0,0,1.
   - Required: col_out stable while stalled, pix_ready=0 during stalls, no lost or duplicate columns (8 total, same values).
3. Per-channel distinct data (channel c pixel = c*8+x, W=3, H=3).
   - Required: 3 columns; channel 17 slot r2 at bits [(17*3+2)*8 +: 8] = 136+x.
4. start with cfg_width=2 (or cfg_height=2).
   - Required: pix_ready never asserted, no col_valid, done pulse on the next cycle, back in IDLE.
5. rst asserted in STREAM mid-row, then a new W=4,H=3 frame.
   - Required: outputs 0 on the cycle after rst, no done for the aborted frame; the new frame yields exactly 4 correct columns.
6. Second start pulsed while busy, then a start in the same cycle as done.
   - Required: the first is ignored; the second launches a new frame immediately with correct output.
